// File: rtl/prj_processor_pio_pkg.sv
// Shared definitions for the processor PIO blocks: register map and edge-type encodings.
package prj_processor_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int unsigned EDGE_RISING  = 0;
   localparam int unsigned EDGE_FALLING = 1;
   localparam int unsigned EDGE_ANY     = 2;

   function automatic logic [31:0] edge_event(input logic [31:0] cur,
                                              input logic [31:0] prev,
                                              input int unsigned edge_type);
      case (edge_type)
         EDGE_RISING:  edge_event = cur & ~prev;
         EDGE_FALLING: edge_event = ~cur & prev;
         default:      edge_event = cur ^ prev;
      endcase
   endfunction

endpackage

// File: rtl/prj_processor_key_pio_in_if.sv
// Avalon-MM slave bus bundle for the key input PIO.
interface prj_processor_key_pio_in_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/prj_processor_pio_debounce.sv
// One input bit: synchronizer chain followed by a stable-count debouncer.
module prj_processor_pio_debounce #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter bit          RESET_LEVEL     = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_bit,
   output logic level
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
      end
   end

   if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            level_q <= RESET_LEVEL;
         end else begin
            level_q <= sync_q[SYNC_STAGES-1];
         end
      end
   end else begin : g_count
      localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_q;

      // Counter stops at CNT_LAST because that cycle always accepts the new level.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            level_q <= RESET_LEVEL;
            cnt_q   <= '0;
         end else if (sync_q[SYNC_STAGES-1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            level_q <= sync_q[SYNC_STAGES-1];
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign level = level_q;

endmodule

// File: rtl/prj_processor_key_pio_in.sv
// Avalon-MM input PIO: debounced key levels, edge-capture register and maskable irq.
module prj_processor_key_pio_in
   import prj_processor_pio_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned EDGE_TYPE       = 1,
   parameter bit          RESET_LEVEL     = 1'b1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   prj_processor_key_pio_in_if.slave   bus,
   input  logic [WIDTH-1:0]            in_port,
   output logic                        irq
);

   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] level_d_q;
   logic             hist_valid_q;
   logic [WIDTH-1:0] edge_capture_q;
   logic [WIDTH-1:0] irq_mask_q;
   logic             irq_q;
   logic [31:0]      ev_full;
   logic [WIDTH-1:0] ev;
   logic [WIDTH-1:0] clr;
   logic             wr_en;
   logic [31:0]      rdata;
   logic             unused_ok;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      prj_processor_pio_debounce #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_LEVEL    (RESET_LEVEL)
      ) u_debounce (
         .clk    (clk),
         .reset_n(reset_n),
         .in_bit (in_port[i]),
         .level  (level[i])
      );
   end

   // History starts at 0 but is ignored until loaded once, so the reset level
   // itself never looks like an edge.
   assign ev_full = edge_event(32'(level), 32'(level_d_q), EDGE_TYPE);
   assign ev      = ev_full[WIDTH-1:0] & {WIDTH{hist_valid_q}};

   assign wr_en = bus.chipselect & ~bus.write_n;
   assign clr   = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_d_q      <= '0;
         hist_valid_q   <= 1'b0;
         edge_capture_q <= '0;
         irq_mask_q     <= '0;
         irq_q          <= 1'b0;
      end else begin
         level_d_q      <= level;
         hist_valid_q   <= 1'b1;
         edge_capture_q <= (edge_capture_q & ~clr) | ev;
         if (wr_en && bus.address == ADDR_IRQMASK) begin
            irq_mask_q <= bus.writedata[WIDTH-1:0];
         end
         irq_q <= |(edge_capture_q & irq_mask_q);
      end
   end

   always_comb begin
      rdata = '0;
      if (bus.chipselect) begin
         case (bus.address)
            ADDR_DATA:    rdata[WIDTH-1:0] = level;
            ADDR_IRQMASK: rdata[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGECAP: rdata[WIDTH-1:0] = edge_capture_q;
            default:      rdata = '0;
         endcase
      end
   end

   assign bus.readdata = rdata;
   assign irq          = irq_q;

   assign unused_ok = ^{bus.writedata, ev_full};

endmodule
